// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Packs a byte stream MSB-first into words and writes them from address 0.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic              we,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_wcnt;
  logic [1:0]          r_bcnt;
  logic [ADDR_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic                r_we;
  logic                r_busy;
  logic                r_done;

  logic [ADDR_W:0]     w_len;
  logic [ADDR_W:0]     w_wnext;
  logic                w_accept;

  // Clamp so the address never wraps back onto word 0.
  assign w_len    = (word_count > LP_DEPTH) ? LP_DEPTH : word_count;
  assign w_wnext  = r_wcnt + (ADDR_W+1)'(1);
  assign w_accept = byte_valid && (r_state == RECV);

  assign byte_ready = (r_state == RECV);
  assign a          = r_a;
  assign d          = r_d;
  assign we         = r_we;
  assign busy       = r_busy;
  assign cpu_hold   = r_busy;
  assign done       = r_done;

  // Loader FSM with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (word_count == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RECV;
              r_len   <= w_len;
              r_wcnt  <= '0;
              r_bcnt  <= '0;
              r_a     <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        RECV: begin
          if (w_accept) begin
            r_d <= {r_d[DATA_W-9:0], byte_in};
            if (r_bcnt == 2'd3) begin
              r_bcnt  <= '0;
              r_we    <= 1'b1;
              r_state <= WRITE;
            end else begin
              r_bcnt <= r_bcnt + 2'd1;
            end
          end
        end
        WRITE: begin
          r_we   <= 1'b0;
          r_wcnt <= w_wnext;
          if (w_wnext == r_len) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_a     <= r_a + (ADDR_W)'(1);
            r_state <= RECV;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Writes are logged on the falling edge and checked per scenario.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [9:0]  a;
  logic [31:0] d;
  logic        we;
  logic        busy;
  logic        cpu_hold;
  logic        done;

  imem_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .a          (a),
    .d          (d),
    .we         (we),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic        br;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  acc_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_seen = 1;
    if (we) wq.push_back('{a: a, d: d, br: byte_ready, cyc: cyc});
  end

  function automatic logic [7:0] pat(input int i);
    int v;
    v = i * 7 + 3;
    return v[7:0];
  endfunction

  task automatic clear_logs();
    wq.delete();
    acc_q.delete();
    busy_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_load(input int n);
    @(negedge clk);
    start = 1'b1;
    word_count = 11'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in = b;
    for (int k = 0; k < 50 && !byte_ready; k++) @(negedge clk);
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept: byte_ready=%b required 1", byte_ready);
    end
    acc_q.push_back(cyc);
    @(posedge clk);
  endtask

  task automatic end_stream();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget && !done; k++) @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_done: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({byte_ready, a, d, we, busy, cpu_hold, done} !== '0) begin
      miscompares++;
      $display("FAIL reset: br=%b a=%h d=%h we=%b busy=%b hold=%b done=%b required all 0",
               byte_ready, a, d, we, busy, cpu_hold, done);
    end
  endtask

  task automatic test_two_word();
    logic [7:0] bs [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    clear_logs();
    start_load(2);
    vectors++;
    if ({busy, cpu_hold, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL two_busy: busy/hold/done=%b%b%b required 110", busy, cpu_hold, done);
    end
    for (int i = 0; i < 8; i++) send_byte(bs[i], 0);
    end_stream();
    wait_done(20);
    vectors++;
    if (wq.size() != 2) begin
      miscompares++;
      $display("FAIL two_count: writes=%0d required 2", wq.size());
    end else begin
      vectors++;
      if (wq[0].a !== 10'd0 || wq[0].d !== 32'h12345678) begin
        miscompares++;
        $display("FAIL two_w0: a=%0d d=%h required 0 12345678", wq[0].a, wq[0].d);
      end
      vectors++;
      if (wq[1].a !== 10'd1 || wq[1].d !== 32'h9ABCDEF0) begin
        miscompares++;
        $display("FAIL two_w1: a=%0d d=%h required 1 9abcdef0", wq[1].a, wq[1].d);
      end
      vectors++;
      if (wq[0].cyc != acc_q[3] + 1 || wq[1].cyc != acc_q[7] + 1) begin
        miscompares++;
        $display("FAIL two_latency: w0 cyc=%0d w1 cyc=%0d required %0d %0d",
                 wq[0].cyc, wq[1].cyc, acc_q[3] + 1, acc_q[7] + 1);
      end
    end
    vectors++;
    if (acc_q[4] - acc_q[3] != 2) begin
      miscompares++;
      $display("FAIL two_stall: gap=%0d required 2", acc_q[4] - acc_q[3]);
    end
    vectors++;
    if ({done, busy, cpu_hold, we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL two_done: done/busy/hold/we=%b%b%b%b required 1000",
               done, busy, cpu_hold, we);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bs [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    clear_logs();
    start_load(2);
    for (int i = 0; i < 8; i++) send_byte(bs[i], (i % 2 == 1) ? 2 : 0);
    end_stream();
    wait_done(30);
    vectors++;
    if (wq.size() != 2) begin
      miscompares++;
      $display("FAIL bp_count: writes=%0d required 2", wq.size());
    end else begin
      vectors++;
      if (wq[0].a !== 10'd0 || wq[0].d !== 32'h12345678 ||
          wq[1].a !== 10'd1 || wq[1].d !== 32'h9ABCDEF0) begin
        miscompares++;
        $display("FAIL bp_data: %0d:%h %0d:%h required 0:12345678 1:9abcdef0",
                 wq[0].a, wq[0].d, wq[1].a, wq[1].d);
      end
      vectors++;
      if (wq[0].br !== 1'b0 || wq[1].br !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready_in_write: br=%b%b required 00", wq[0].br, wq[1].br);
      end
    end
    vectors++;
    if (acc_q[4] - acc_q[3] != 2) begin
      miscompares++;
      $display("FAIL bp_stall: gap=%0d required 2", acc_q[4] - acc_q[3]);
    end
  endtask

  task automatic test_zero_length();
    do_reset();
    clear_logs();
    start_load(0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (wq.size() != 0 || busy_seen != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_quiet: writes=%0d busy_seen=%0d done=%b required 0 0 1",
               wq.size(), busy_seen, done);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bs [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    logic [7:0] cs [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    clear_logs();
    start_load(3);
    for (int i = 0; i < 6; i++) send_byte(bs[i], 0);
    end_stream();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({byte_ready, a, d, we, busy, cpu_hold, done} !== '0) begin
      miscompares++;
      $display("FAIL rmid_state: br=%b a=%h d=%h we=%b busy=%b hold=%b done=%b required all 0",
               byte_ready, a, d, we, busy, cpu_hold, done);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (wq.size() != 1 || wq[0].a !== 10'd0 || wq[0].d !== 32'h12345678) begin
      miscompares++;
      $display("FAIL rmid_writes: writes=%0d required 1 at a=0 d=12345678", wq.size());
    end
    start_load(1);
    for (int i = 0; i < 4; i++) send_byte(cs[i], 0);
    end_stream();
    wait_done(20);
    vectors++;
    if (wq.size() != 2 || wq[1].a !== 10'd0 || wq[1].d !== 32'hAABBCCDD) begin
      miscompares++;
      $display("FAIL rmid_reload: writes=%0d last a=%0d d=%h required 2 0 aabbccdd",
               wq.size(), wq[wq.size()-1].a, wq[wq.size()-1].d);
    end
  endtask

  task automatic test_ignored_start();
    do_reset();
    clear_logs();
    start_load(2);
    for (int i = 0; i < 4; i++) send_byte(pat(i), 0);
    end_stream();
    start_load(5);
    for (int i = 4; i < 8; i++) send_byte(pat(i), 0);
    end_stream();
    wait_done(20);
    repeat (10) @(negedge clk);
    vectors++;
    if (wq.size() != 2 || wq[1].a !== 10'd1 ||
        wq[1].d !== {pat(4), pat(5), pat(6), pat(7)}) begin
      miscompares++;
      $display("FAIL ign_writes: writes=%0d last a=%0d required 2 1",
               wq.size(), wq[wq.size()-1].a);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_done: done=%b busy=%b required 1 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    start_load(1);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm: done=%b busy=%b required 0 1", done, busy);
    end
    for (int i = 0; i < 4; i++) send_byte(pat(i + 40), 0);
    end_stream();
    wait_done(20);
    vectors++;
    if (wq.size() != 1 || wq[0].a !== 10'd0 ||
        wq[0].d !== {pat(40), pat(41), pat(42), pat(43)}) begin
      miscompares++;
      $display("FAIL rearm_write: writes=%0d required 1 at a=0", wq.size());
    end
  endtask

  task automatic test_full_clamp();
    int bad_a;
    int bad_d;
    bad_a = 0;
    bad_d = 0;
    do_reset();
    clear_logs();
    start_load(1100);
    for (int i = 0; i < 4096; i++) send_byte(pat(i), 0);
    end_stream();
    wait_done(20);
    repeat (5) @(negedge clk);
    vectors++;
    if (wq.size() != 1024) begin
      miscompares++;
      $display("FAIL full_count: writes=%0d required 1024", wq.size());
    end else begin
      for (int k = 0; k < 1024; k++) begin
        if (wq[k].a !== 10'(k)) bad_a++;
        if (wq[k].d !== {pat(4*k), pat(4*k+1), pat(4*k+2), pat(4*k+3)}) bad_d++;
      end
      vectors++;
      if (bad_a != 0) begin
        miscompares++;
        $display("FAIL full_addr: bad addresses=%0d required 0", bad_a);
      end
      vectors++;
      if (bad_d != 0) begin
        miscompares++;
        $display("FAIL full_data: bad words=%0d required 0", bad_d);
      end
    end
    vectors++;
    if (done !== 1'b1 || a !== 10'd1023) begin
      miscompares++;
      $display("FAIL full_done: done=%b a=%0d required 1 1023", done, a);
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_backpressure();
    test_zero_length();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_full_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
